// File: rtl/i2c_clk_gen_mod.sv
// rtl/i2c_clk_gen_mod.sv - I2C SCL bit-timing generator: phase accumulator, quarter-phase strobes, stretch hold
// Runs entirely in clk_i; scl_o and ph_o are registered so the byte engine sees clean, glitch-free timing.
module i2c_clk_gen_mod #(
    parameter int unsigned       ACC_W        = 32,
    parameter int unsigned       IN_CLK_FREQ  = 100000000,
    parameter int unsigned       DEF_OUT_FREQ = 400000,
    parameter logic [ACC_W-1:0]  DEF_INC      = ACC_W'(
        (((64'(DEF_OUT_FREQ) * 64'd4) << ACC_W) + 64'(IN_CLK_FREQ / 2)) / 64'(IN_CLK_FREQ))
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             inc_load_i,
    input  logic             scl_i,
    output logic             scl_o,
    output logic [3:0]       ph_o,
    output logic             stretch_o,
    output logic             cfg_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       age_q, age_d;
    logic [ACC_W-1:0] inc_act_q, inc_act_d;
    logic [ACC_W-1:0] inc_pend_q, inc_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             scl_q, scl_d;
    logic [3:0]       ph_q, ph_d;
    logic             cfg_err_q, cfg_err_d;
    logic             sync1_q, sync2_q;

    logic [ACC_W:0]   sum;
    logic             tick;
    logic [1:0]       phase_nx;
    logic             hold_req;
    logic             start;
    logic             adv;
    logic             wrap;
    logic             load_ok;
    logic             load_bad;
    logic             transfer;

    // Two-flop synchroniser for the asynchronous SCL sense input
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= scl_i;
            sync2_q <= sync1_q;
        end
    end

    assign sum      = {1'b0, acc_q} + {1'b0, inc_act_q};
    assign tick     = sum[ACC_W];
    assign phase_nx = phase_q + 2'd1;

    // The synchroniser still carries the pre-release low level for the first
    // two cycles of phase 2, so a stretch is only recognised once age_q saturates.
    assign hold_req = (phase_q == 2'd2) && (age_q == 2'd2) && !sync2_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (hold_req) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (sync2_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        start = 1'b0;
        adv   = 1'b0;
        case (state_q)
            ST_IDLE: start = en_i;
            ST_RUN:  adv   = en_i && !hold_req;
            ST_HOLD: adv   = en_i && sync2_q;
            default: begin
                start = 1'b0;
                adv   = 1'b0;
            end
        endcase
    end

    assign stretch_o = (state_q == ST_HOLD);

    assign wrap     = adv && tick && (phase_q == 2'd3);
    assign load_ok  = inc_load_i && (inc_i != '0);
    assign load_bad = inc_load_i && (inc_i == '0);
    // Rate changes only land on a period boundary or while idle
    assign transfer = pend_v_q && (!en_i || wrap);

    // Accumulator, phase and strobe datapath
    always_comb begin
        acc_d   = acc_q;
        phase_d = phase_q;
        age_d   = age_q;
        scl_d   = scl_q;
        ph_d    = 4'b0000;
        if (!en_i) begin
            acc_d   = '0;
            phase_d = 2'd0;
            age_d   = 2'd0;
            scl_d   = 1'b1;
        end else if (start) begin
            // Enable edge is the entry into phase 0, like a 3->0 wrap with acc cleared
            acc_d   = '0;
            phase_d = 2'd0;
            age_d   = 2'd0;
            scl_d   = 1'b0;
            ph_d    = 4'b0001;
        end else begin
            if (adv) begin
                acc_d = sum[ACC_W-1:0];
            end
            if (adv && tick) begin
                phase_d = phase_nx;
                age_d   = 2'd0;
                scl_d   = phase_nx[1];
                ph_d    = 4'b0001 << phase_nx;
            end else if (age_q != 2'd2) begin
                age_d = age_q + 2'd1;
            end
        end
    end

    // Increment staging and load validation
    always_comb begin
        inc_act_d  = inc_act_q;
        inc_pend_d = inc_pend_q;
        pend_v_d   = pend_v_q;
        cfg_err_d  = load_bad;
        if (transfer) begin
            inc_act_d = inc_pend_q;
            pend_v_d  = 1'b0;
        end
        if (load_ok) begin
            inc_pend_d = inc_i;
            pend_v_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q      <= '0;
            phase_q    <= 2'd0;
            age_q      <= 2'd0;
            inc_act_q  <= DEF_INC;
            inc_pend_q <= DEF_INC;
            pend_v_q   <= 1'b0;
            scl_q      <= 1'b1;
            ph_q       <= 4'b0000;
            cfg_err_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            phase_q    <= phase_d;
            age_q      <= age_d;
            inc_act_q  <= inc_act_d;
            inc_pend_q <= inc_pend_d;
            pend_v_q   <= pend_v_d;
            scl_q      <= scl_d;
            ph_q       <= ph_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign scl_o     = scl_q;
    assign ph_o      = ph_q;
    assign cfg_err_o = cfg_err_q;

endmodule
